// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states,
// immediate formats and trap causes. The immediate extender imports imm_sel_e too.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_ZERO = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_e;

  typedef enum logic [2:0] {
    OPK_OP_IMM,
    OPK_OP,
    OPK_LOAD,
    OPK_STORE,
    OPK_BRANCH,
    OPK_ILLEGAL
  } opk_e;

  function automatic opk_e decode_opcode(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM: return OPK_OP_IMM;
      OPC_OP:     return OPK_OP;
      OPC_LOAD:   return OPK_LOAD;
      OPC_STORE:  return OPK_STORE;
      OPC_BRANCH: return OPK_BRANCH;
      default:    return OPK_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the multi-cycle controller (master) and the
// shared datapath plus memory port (slave).
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic [1:0]  imm_sel;
  logic        alu_src_b;
  logic        reg_write;
  logic        wb_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  modport master (
    input  instr, mem_ready, branch_taken,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sel,
           alu_src_b, reg_write, wb_sel, trap, trap_cause, state
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sel,
           alu_src_b, reg_write, wb_sel, trap, trap_cause, state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired fires in the wait cycle that brings the
// count up to TIMEOUT, so TIMEOUT=1 expires on the very first unanswered request.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back
// over one shared datapath and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master ctrl_if
);

  state_e      state_q, state_d;
  logic        trap_q, trap_d;
  trap_cause_e cause_q, cause_d;
  opk_e        opk;
  logic        tmr_clear, tmr_en, tmr_expired;
  logic        unused_instr;

  assign opk          = decode_opcode(ctrl_if.instr[6:0]);
  assign unused_instr = ^ctrl_if.instr[31:7];

  // The timer restarts on every state change, which covers entry to FETCH and MEM.
  assign tmr_en    = ctrl_if.mem_req & ~ctrl_if.mem_ready;
  assign tmr_clear = (state_d != state_q);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      ST_FETCH: begin
        if (ctrl_if.mem_ready) state_d = ST_DECODE;
        else if (tmr_expired) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (opk == OPK_ILLEGAL) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opk)
          OPK_OP, OPK_OP_IMM:  state_d = ST_WB;
          OPK_LOAD, OPK_STORE: state_d = ST_MEM;
          default:             state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (ctrl_if.mem_ready) state_d = (opk == OPK_LOAD) ? ST_WB : ST_FETCH;
        else if (tmr_expired) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    ctrl_if.mem_req   = 1'b0;
    ctrl_if.mem_we    = 1'b0;
    ctrl_if.addr_sel  = 1'b0;
    ctrl_if.ir_write  = 1'b0;
    ctrl_if.pc_write  = 1'b0;
    ctrl_if.pc_src    = 1'b0;
    ctrl_if.imm_sel   = IMM_I;
    ctrl_if.alu_src_b = 1'b0;
    ctrl_if.reg_write = 1'b0;
    ctrl_if.wb_sel    = 1'b0;

    // Operand selects follow the opcode once the instruction register is valid.
    if (state_q != ST_FETCH && state_q != ST_TRAP) begin
      case (opk)
        OPK_OP_IMM, OPK_LOAD: ctrl_if.imm_sel = IMM_I;
        OPK_STORE:            ctrl_if.imm_sel = IMM_S;
        OPK_BRANCH:           ctrl_if.imm_sel = IMM_B;
        default:              ctrl_if.imm_sel = IMM_ZERO;
      endcase
      ctrl_if.alu_src_b = (opk == OPK_OP_IMM) || (opk == OPK_LOAD) || (opk == OPK_STORE);
    end

    case (state_q)
      ST_FETCH: begin
        ctrl_if.mem_req  = 1'b1;
        ctrl_if.ir_write = ctrl_if.mem_ready;
      end
      ST_EXEC: begin
        if (opk == OPK_BRANCH) begin
          ctrl_if.pc_write = 1'b1;
          ctrl_if.pc_src   = ctrl_if.branch_taken;
        end
      end
      ST_MEM: begin
        ctrl_if.mem_req  = 1'b1;
        ctrl_if.addr_sel = 1'b1;
        ctrl_if.mem_we   = (opk == OPK_STORE);
        ctrl_if.pc_write = (opk == OPK_STORE) && ctrl_if.mem_ready;
      end
      ST_WB: begin
        ctrl_if.reg_write = 1'b1;
        ctrl_if.wb_sel    = (opk == OPK_LOAD);
        ctrl_if.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl_if.trap       = trap_q;
  assign ctrl_if.trap_cause = cause_q;
  assign ctrl_if.state      = state_q;

endmodule
